// File: rtl/if_stage_n_pkg.sv
// if_stage_n_pkg: shared fetch-stage state encoding and width constants
package if_stage_n_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = 32'hBFC00000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/if_inst_queue.sv
// if_inst_queue: circular instruction queue with up-to-FW writes, one read and a flush that still accepts writes
module if_inst_queue
  import if_stage_n_pkg::*;
#(
  parameter int FW = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(FW + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [CW-1:0]              wr_cnt,
  input  logic [FW-1:0][PC_W-1:0]    wr_pc,
  input  logic [FW-1:0][INST_W-1:0]  wr_inst,
  input  logic                       rd_en,
  output logic                       empty,
  output logic [AW:0]                free_cnt,
  output logic [PC_W-1:0]            rd_pc,
  output logic [INST_W-1:0]          rd_inst
);
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [AW-1:0] head, tail, base;
  logic [AW:0] count;
  assign base = flush ? '0 : tail;
  assign empty = count == '0;
  assign free_cnt = (AW+1)'(DEPTH) - count;
  assign rd_pc = empty ? '0 : mem_pc[head];
  assign rd_inst = empty ? '0 : mem_inst[head];
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= flush ? '0 : head + AW'(rd_en);
      tail <= base + AW'(wr_cnt);
      count <= (flush ? '0 : count - (AW+1)'(rd_en)) + (AW+1)'(wr_cnt);
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < FW; i++) begin
      if (i < int'(wr_cnt)) begin
        mem_pc[base + AW'(i)] <= wr_pc[i];
        mem_inst[base + AW'(i)] <= wr_inst[i];
      end
    end
  end
endmodule

// File: rtl/if_stage_n.sv
// if_stage_n: instruction fetch stage feeding decode through an instruction queue
module if_stage_n
  import if_stage_n_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC = if_stage_n_pkg::RESET_PC
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_redirect_valid,
  input  logic [PC_W-1:0]               io_redirect_pc,
  input  logic                          io_bc_branch_cache_overwrite,
  input  logic [INST_W-1:0]             io_bc_inst,
  output logic                          io_cache_req_valid,
  input  logic                          io_cache_req_ready,
  output logic [PC_W-1:0]               io_cache_addr,
  input  logic                          io_cache_resp_valid,
  input  logic [FETCH_WIDTH*INST_W-1:0] io_cache_dout,
  output logic                          io_out_valid,
  input  logic                          io_out_ready,
  output logic [PC_W-1:0]               io_out_pc,
  output logic [INST_W-1:0]             io_out_inst
);
  localparam int CW = $clog2(FETCH_WIDTH + 1);
  localparam int AW = $clog2(QUEUE_DEPTH);
  fetch_state_t state;
  logic [PC_W-1:0] fpc, base, redir_pc;
  logic drop, resp_take, empty;
  logic [CW-1:0] k, wr_cnt;
  logic [FETCH_WIDTH-1:0][PC_W-1:0] wr_pc;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] wr_inst;
  logic [AW:0] free_cnt;
  assign base = fpc & ~PC_W'(FETCH_WIDTH * 4 - 1);
  assign k = CW'((fpc >> 2) & PC_W'(FETCH_WIDTH - 1));
  assign redir_pc = {io_redirect_pc[PC_W-1:2], 2'b00};
  assign io_cache_addr = base;
  assign io_cache_req_valid = state == REQ;
  assign io_out_valid = !empty;
  always_comb begin
    resp_take = state == WAIT && io_cache_resp_valid && !io_redirect_valid;
    wr_cnt = io_redirect_valid ? CW'(io_bc_branch_cache_overwrite) : resp_take ? CW'(FETCH_WIDTH) - k : '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_pc[i] = (i == 0 && io_redirect_valid) ? redir_pc : base + PC_W'(((int'(k) + i) % FETCH_WIDTH) * 4);
      wr_inst[i] = (i == 0 && io_redirect_valid) ? io_bc_inst : io_cache_dout[((int'(k) + i) % FETCH_WIDTH) * INST_W +: INST_W];
    end
  end
  always_ff @(posedge clock) begin
    if (reset || io_redirect_valid) begin
      state <= IDLE;
      drop <= (state == WAIT || (state == REQ && io_cache_req_ready) || drop) && !io_cache_resp_valid;
      fpc <= reset ? RESET_PC : redir_pc + (io_bc_branch_cache_overwrite ? PC_W'(4) : '0);
    end else begin
      drop <= drop && !io_cache_resp_valid;
      fpc <= resp_take ? base + PC_W'(FETCH_WIDTH * 4) : fpc;
      state <= (state == IDLE && free_cnt >= (AW+1)'(FETCH_WIDTH) && !drop) ? REQ :
               (state == REQ && io_cache_req_ready) ? WAIT :
               (state == WAIT && io_cache_resp_valid) ? IDLE : state;
    end
  end
  if_inst_queue #(.FW(FETCH_WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clock,
    .reset,
    .flush(io_redirect_valid),
    .wr_cnt,
    .wr_pc,
    .wr_inst,
    .rd_en(io_out_valid && io_out_ready),
    .empty,
    .free_cnt,
    .rd_pc(io_out_pc),
    .rd_inst(io_out_inst)
  );
endmodule
